// File: rtl/spi_ram_slave.sv
// ---------------------------------------------------------------------------
// spi_ram_slave
//   SPI slave front end fused with a single-port byte RAM, clocked from the
//   system clock (no separate SCK). While SS_n is low, the first sampled bit
//   selects the receive path and the next 10 bits form a frame:
//   {cmd[1:0], payload[7:0]}, MSB first.
//     cmd 00 : load write address
//     cmd 01 : write payload to mem[wr_addr]
//     cmd 10 : load read address (arms the read-data path)
//     cmd 11 : fetch mem[rd_addr]; shifted out on MISO when on the
//              READ_DATA path
//
// Optional build macro:
//   SPI_RAM_MEM_CLR_EN - when defined, rst also clears every RAM word to
//                        8'h00. When undefined, the RAM holds its contents
//                        across reset and maps onto inferred block RAM.
// ---------------------------------------------------------------------------
module spi_ram_slave #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);

   // Index width for the RAM array; addresses wrap modulo MEM_DEPTH.
   localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   // Number of bits in one frame (2 command bits + 8 payload bits).
   localparam logic [3:0] FRAME_BITS = 4'd10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   // Receive side
   logic [9:0]  rx_shift;      // frame shift register, doubles as rx_data
   logic [3:0]  bit_cnt;       // frame bits received so far (0..10)
   logic        rx_valid;      // one-cycle pulse: rx_shift holds a full frame
   logic [9:0]  rx_data;

   // RAM side
   logic [7:0]  mem [0:MEM_DEPTH-1];
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [MEM_AW-1:0]    wr_idx;
   logic [MEM_AW-1:0]    rd_idx;
   logic        rd_addr_seen;  // a read address has been loaded since last read-out
   logic [7:0]  dout;          // registered RAM read data
   logic        tx_valid;      // dout holds fresh read data for transmission
   logic        mem_we;

   // Transmit side
   logic [7:0]  tx_shift;      // remaining bits to send, MSB aligned
   logic [2:0]  tx_cnt;        // bits still to send after the current one
   logic        tx_busy;       // MISO currently carries a data bit
   logic        tx_done;       // byte sent; stay quiet until SS_n rises
   logic        miso_q;

   // Decoded FSM controls
   logic        in_rx_state;
   logic        rx_shift_en;
   logic        rx_last;
   logic        tx_start;
   logic        tx_end;

   assign rx_data = rx_shift;
   assign MISO    = miso_q;

   // Address wrap: reduce the addresses modulo the RAM depth.
   assign wr_idx = MEM_AW'(32'(wr_addr) % 32'(MEM_DEPTH));
   assign rd_idx = MEM_AW'(32'(rd_addr) % 32'(MEM_DEPTH));

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: SS_n high forces IDLE from any state.
   always_comb begin
      state_next = state;
      if (SS_n) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:      state_next = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI) begin
                  state_next = WRITE;
               end else if (rd_addr_seen) begin
                  state_next = READ_DATA;
               end else begin
                  state_next = READ_ADD;
               end
            end
            WRITE:     state_next = WRITE;
            READ_ADD:  state_next = READ_ADD;
            READ_DATA: state_next = READ_DATA;
            default:   state_next = IDLE;
         endcase
      end
   end

   // Output decode: receive/transmit strobes derived from the current state.
   always_comb begin
      in_rx_state = 1'b0;
      rx_shift_en = 1'b0;
      rx_last     = 1'b0;
      tx_start    = 1'b0;
      tx_end      = 1'b0;
      case (state)
         WRITE, READ_ADD, READ_DATA: in_rx_state = 1'b1;
         default:                    in_rx_state = 1'b0;
      endcase
      // Bits beyond the tenth are ignored until SS_n rises.
      rx_shift_en = in_rx_state && !SS_n && (bit_cnt != FRAME_BITS);
      rx_last     = rx_shift_en && (bit_cnt == FRAME_BITS - 4'd1);
      // Transmission only happens on the READ_DATA path, once per frame.
      tx_start    = (state == READ_DATA) && !SS_n && tx_valid
                    && !tx_busy && !tx_done;
      tx_end      = tx_busy && !SS_n && (tx_cnt == 3'd0);
   end

   // ------------------------------------------------------------------
   // Receive shifter
   // ------------------------------------------------------------------

   // Shift MOSI into the frame register and pulse rx_valid on the 10th bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_shift <= '0;
         bit_cnt  <= '0;
         rx_valid <= 1'b0;
      end else if (SS_n) begin
         // Deselect discards any partial frame.
         bit_cnt  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= rx_last;
         if (rx_shift_en) begin
            rx_shift <= {rx_shift[8:0], MOSI};
            bit_cnt  <= bit_cnt + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // RAM control and storage
   // ------------------------------------------------------------------

   assign mem_we = rx_valid && (rx_data[9:8] == 2'b01);

   // Decode completed frames into address loads, read fetches and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr      <= '0;
         rd_addr      <= '0;
         rd_addr_seen <= 1'b0;
         dout         <= '0;
         tx_valid     <= 1'b0;
      end else begin
         if (rx_valid) begin
            case (rx_data[9:8])
               2'b00: wr_addr <= ADDR_SIZE'(rx_data[7:0]);
               2'b10: begin
                  rd_addr      <= ADDR_SIZE'(rx_data[7:0]);
                  rd_addr_seen <= 1'b1;
               end
               2'b11: begin
                  dout     <= mem[rd_idx];
                  tx_valid <= 1'b1;
               end
               default: ;  // 01 is handled by the RAM write port
            endcase
         end
         // Completing a read-out re-arms the read-address path.
         if (tx_end) begin
            tx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
         end
         // Stale read data never survives a deselect.
         if (SS_n) begin
            tx_valid <= 1'b0;
         end
      end
   end

`ifdef SPI_RAM_MEM_CLR_EN
   // RAM write port with reset clear of every word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (mem_we) begin
         mem[wr_idx] <= rx_data[7:0];
      end
   end
`else
   // RAM write port; contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_idx] <= rx_data[7:0];
      end
   end
`endif

   // ------------------------------------------------------------------
   // Transmit shifter
   // ------------------------------------------------------------------

   // Latch dout once tx_valid is seen and shift it out MSB first for 8 clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift <= '0;
         tx_cnt   <= '0;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         miso_q   <= 1'b0;
      end else if (SS_n) begin
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         tx_cnt   <= '0;
         miso_q   <= 1'b0;
      end else if (tx_start) begin
         miso_q   <= dout[7];
         tx_shift <= {dout[6:0], 1'b0};
         tx_cnt   <= 3'd7;
         tx_busy  <= 1'b1;
      end else if (tx_busy) begin
         if (tx_cnt == 3'd0) begin
            // Last bit has been on the line for one clock: go quiet.
            miso_q  <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
         end else begin
            miso_q   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
            tx_cnt   <= tx_cnt - 3'd1;
         end
      end else begin
         miso_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_slave
//   Directed bench for spi_ram_slave. Inputs change on the falling edge and
//   MISO is sampled on the falling edge, half a clock away from the rising
//   edge on which the DUT samples and drives. Expected bytes are hand-derived.
// ---------------------------------------------------------------------------
module tb_spi_ram_slave;

   logic clk = 1'b0;
   logic rst;
   logic SS_n;
   logic MOSI;
   logic MISO;

   int total = 0;
   int bad   = 0;

   spi_ram_slave #(
      .MEM_DEPTH(256),
      .ADDR_SIZE(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .SS_n(SS_n),
      .MOSI(MOSI),
      .MISO(MISO)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it does not hold.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Select, then clock nbits of the frame MSB first. Returns on the falling
   // edge right after the last bit was sampled.
   task automatic send_frame(input logic sel, input logic [9:0] frame, input int nbits);
      SS_n = 1'b0;
      MOSI = 1'b0;
      @(negedge clk);
      MOSI = sel;
      @(negedge clk);
      for (int i = 9; i > 9 - nbits; i--) begin
         MOSI = frame[i];
         @(negedge clk);
      end
      $display("frame sel=%0b cmd=%b data=%h bits=%0d", sel, frame[9:8], frame[7:0], nbits);
   endtask

   // Deselect and leave the bus idle for two clocks.
   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Called right after a READ_DATA 11-frame: expects two quiet clocks, then
   // the byte MSB first, then MISO back at 0.
   task automatic read_expect(input string tag, input logic [7:0] exp);
      logic [7:0] got;
      got = '0;
      chk($sformatf("%s_lat0", tag), {7'b0, MISO}, 8'h00);
      @(negedge clk);
      chk($sformatf("%s_lat1", tag), {7'b0, MISO}, 8'h00);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         got[i] = MISO;
         chk($sformatf("%s_bit%0d", tag, i), {7'b0, MISO}, {7'b0, exp[i]});
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("%s_tail%0d", tag, k), {7'b0, MISO}, 8'h00);
      end
      $display("read %s: shifted %h want %h", tag, got, exp);
   endtask

   // MISO must stay at 0 for n clocks.
   task automatic silent(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s_q%0d", tag, k), {7'b0, MISO}, 8'h00);
         @(negedge clk);
      end
      $display("silent %s: %0d clocks checked", tag, n);
   endtask

   initial begin
      rst  = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_miso", {7'b0, MISO}, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // Write path: wr_addr=AB, extra MOSI bits after the frame ignored.
      send_frame(1'b0, {2'b00, 8'hAB}, 10);
      MOSI = 1'b1;
      repeat (3) @(negedge clk);
      end_frame();
      send_frame(1'b0, {2'b01, 8'hD7}, 10);
      end_frame();

      // Read path: address AB, then data -> D7.
      send_frame(1'b1, {2'b10, 8'hAB}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h52}, 10);
      read_expect("rd_ab", 8'hD7);
      end_frame();

      // Second pattern: mem[10]=5A, read it back, then a 1-select must
      // go to READ_ADD (no transmit) because the flag was cleared.
      send_frame(1'b0, {2'b00, 8'h10}, 10);
      end_frame();
      send_frame(1'b0, {2'b01, 8'h5A}, 10);
      end_frame();
      send_frame(1'b1, {2'b10, 8'h10}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h00}, 10);
      read_expect("rd_10", 8'h5A);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h00}, 10);
      silent("after_read", 14);
      end_frame();

      // Path mismatch: a 10-command on the WRITE path still loads rd_addr.
      send_frame(1'b0, {2'b10, 8'hAB}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'hFF}, 10);
      read_expect("mismatch", 8'hD7);
      end_frame();

      // Abort: mem[20]=33, partial 01 frame with CC must not write.
      send_frame(1'b0, {2'b00, 8'h20}, 10);
      end_frame();
      send_frame(1'b0, {2'b01, 8'h33}, 10);
      end_frame();
      send_frame(1'b0, {2'b01, 8'hCC}, 5);
      end_frame();
      send_frame(1'b1, {2'b10, 8'h20}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h00}, 10);
      read_expect("abort", 8'h33);
      end_frame();
      send_frame(1'b0, {2'b01, 8'h44}, 10);
      end_frame();
      send_frame(1'b1, {2'b10, 8'h20}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h00}, 10);
      read_expect("post_abort", 8'h44);
      end_frame();

      // Reset during a transmission: MISO drops at once.
      send_frame(1'b1, {2'b10, 8'hAB}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h00}, 10);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_bit7", {7'b0, MISO}, 8'h01);
      #2 rst = 1'b1;
      #1 chk("rst_async_miso", {7'b0, MISO}, 8'h00);
      $display("reset asserted mid-transmit");
      @(negedge clk);
      SS_n = 1'b1;
      rst  = 1'b0;
      @(negedge clk);

      // After reset the flag is clear: an 11-frame goes to READ_ADD, no MISO.
      send_frame(1'b1, {2'b11, 8'hFF}, 10);
      silent("no_rd_addr", 14);
      end_frame();

      // Clean decode after reset; RAM contents survive reset.
      send_frame(1'b1, {2'b10, 8'h10}, 10);
      end_frame();
      send_frame(1'b1, {2'b11, 8'h00}, 10);
      read_expect("post_rst", 8'h5A);
      end_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
